// File: rtl/mdu_opcodes_pkg.sv
// Opcode and state encodings for the mdu, plus per-operation sign helpers.
package mdu_opcodes_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input mdu_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic a_signed(input mdu_op_e op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic b_signed(input mdu_op_e op);
    return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Radix-2 shift-add multiply / restoring divide datapath over unsigned magnitudes.
// hi/lo hold {product} for multiplies and {remainder, quotient} for divides; outputs are the post-step values.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] d_q;
  logic [XLEN-1:0] hi_d;
  logic [XLEN-1:0] lo_d;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Divide keeps remainder < divisor, so diff[XLEN] is a clean borrow flag.
  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? d_q : {XLEN{1'b0}})};
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, d_q};
    if (div_i) begin
      hi_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign hi_o = hi_d;
  assign lo_o = lo_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
      d_q  <= '0;
    end else if (load_i) begin
      hi_q <= '0;
      lo_q <= div_i ? a_i : b_i;
      d_q  <= div_i ? b_i : a_i;
    end else if (step_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/mdu.sv
// RV32M multiply/divide unit: iterative ops take XLEN cycles in CALC (busy_o high), specials finish in one.
// Requests while busy are ignored; flush_i aborts. MDU_FAST_MUL_EN selects a single-cycle multiplier.
module mdu
  import mdu_opcodes_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [2:0]      mdu_op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] CALC = ST_CALC;
  localparam logic [1:0] DONE = ST_DONE;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q;
  logic [CW-1:0]   cnt_q;
  mdu_op_e         op_q;
  logic            neg_q;
  logic [XLEN-1:0] result_q;

  mdu_op_e         op;
  logic            a_neg;
  logic            b_neg;
  logic            res_neg;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic            accept;
  logic            go_iter;
  logic            core_div;
  logic            fast_op;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;
  logic [XLEN-1:0] mag_res;
  logic [XLEN-1:0] calc_res;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    op       = mdu_op_e'(mdu_op_i);
    a_neg    = a_signed(op) & a_i[XLEN-1];
    b_neg    = b_signed(op) & b_i[XLEN-1];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
    // Remainder follows the dividend's sign; everything else is the xor.
    res_neg  = is_rem(op) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div(op) && (b_i == '0);
    div_ovf  = is_div(op) && b_signed(op) && (a_i == MOST_NEG) && (b_i == '1);
    special  = div_zero | div_ovf;
    if (div_zero) begin
      special_res = is_rem(op) ? a_i : '1;
    end else begin
      special_res = is_rem(op) ? '0 : a_i;
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;

  always_comb begin
    fast_prod = {{XLEN{a_neg}}, a_i} * {{XLEN{b_neg}}, b_i};
    fast_res  = (op == MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    fast_op   = !is_div(op);
  end
`else
  assign fast_res = '0;
  assign fast_op  = 1'b0;
`endif

  assign accept   = req_i && !flush_i && (state_q != CALC);
  assign go_iter  = accept && !special && !fast_op;
  assign core_div = (state_q == CALC) ? is_div(op_q) : is_div(op);

  mdu_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load_i(go_iter),
    .step_i(state_q == CALC),
    .div_i (core_div),
    .a_i   (a_mag),
    .b_i   (b_mag),
    .hi_o  (step_hi),
    .lo_o  (step_lo)
  );

  always_comb begin
    prod     = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    mag_res  = is_rem(op_q) ? step_hi : step_lo;
    if (is_div(op_q)) begin
      calc_res = neg_q ? -mag_res : mag_res;
    end else begin
      calc_res = (op_q == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= MUL;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        CALC: begin
          if (cnt_q == '0) begin
            state_q  <= DONE;
            result_q <= calc_res;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          if (req_i) begin
            op_q  <= op;
            neg_q <= res_neg;
            if (special) begin
              result_q <= special_res;
              state_q  <= DONE;
            end else if (fast_op) begin
              result_q <= fast_res;
              state_q  <= DONE;
            end else begin
              state_q <= CALC;
              cnt_q   <= CW'(XLEN - 1);
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy_o   = (state_q == CALC);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboarded bench for mdu: stimulus pushes expected result/timing, a negedge monitor pops on valid_o.
module tb_mdu;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            req_i = 1'b0;
  logic            flush_i = 1'b0;
  logic [2:0]      mdu_op_i = 3'd0;
  logic [XLEN-1:0] a_i = '0;
  logic [XLEN-1:0] b_i = '0;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy_run = 0;
  logic [XLEN-1:0] held;

  typedef struct {
    logic [XLEN-1:0] res;
    int              due;
    int              busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  mdu #(.XLEN(XLEN)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .mdu_op_i(mdu_op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on sign/zero-extended operands.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, ua, sbv, ubv, p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    ua  = {32'd0, a};
    sbv = {{32{b[31]}}, b};
    ubv = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ubv; return p[63:32]; end
      3'd3: begin p = ua * ubv; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4 && b == 0) return 0;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`ifdef MDU_FAST_MUL_EN
    if (op < 3'd4) return 0;
`endif
    return XLEN;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every valid_o must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_i) begin
      busy_run = 0;
    end else if (busy_o) begin
      busy_run++;
    end else begin
      if (valid_o) begin
        chk("valid_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("result", 64'(result_o), 64'(mon_e.res));
          chk("latency", 64'(cyc), 64'(mon_e.due));
          chk("busy_cycles", 64'(busy_run), 64'(mon_e.busy));
        end
      end
      busy_run = 0;
    end
  end

  // Called away from the clock edge; returns 1 time unit after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res);
    exp_t e;
    int   l;
    l        = lat(op, a, b);
    e.res    = res;
    e.due    = cyc + 1 + l;
    e.busy   = l;
    exp_q.push_back(e);
    mdu_op_i = op;
    a_i      = a;
    b_i      = b;
    req_i    = 1'b1;
    @(posedge clk_i);
    #1 req_i = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (!valid_o && n < 100);
    if (!valid_o) chk("valid_timeout", 64'(valid_o), 64'd1);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input bit btb);
    issue(op, a, b, res);
    wait_valid();
    if (!btb) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk_i);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    #1;

    run(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    run(3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
    run(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run(3'd6, 32'd5, 32'd0, 32'd5, 1'b0);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Back-to-back accepts from DONE
    run(3'd4, 32'd1000, 32'd7, 32'd142, 1'b1);
    run(3'd6, 32'h0000_DEAD, 32'h0000_0077, 32'd4, 1'b1);
    run(3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0);

    // New request held during CALC must be ignored
    issue(3'd5, 32'd1000, 32'd3, 32'd333);
    req_i    = 1'b1;
    mdu_op_i = 3'd0;
    a_i      = 32'd5;
    b_i      = 32'd5;
    repeat (10) @(posedge clk_i);
    #1 req_i = 1'b0;
    chk("busy_during_ignored_req", 64'(busy_o), 64'd1);
    wait_valid();
    @(negedge clk_i);
    #1;

    // Flush at CALC cycle 10 with a simultaneous request
    held     = result_o;
    mdu_op_i = 3'd4;
    a_i      = 32'hFFFF_FC18;
    b_i      = 32'd3;
    req_i    = 1'b1;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    chk("pre_flush_busy", 64'(busy_o), 64'd1);
    flush_i  = 1'b1;
    req_i    = 1'b1;
    mdu_op_i = 3'd3;
    a_i      = 32'h1234_5678;
    b_i      = 32'h9ABC_DEF0;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    req_i   = 1'b0;
    chk("flush_busy", 64'(busy_o), 64'd0);
    chk("flush_valid", 64'(valid_o), 64'd0);
    chk("flush_result", 64'(result_o), 64'(held));
    run(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);

    // Asynchronous reset at CALC cycle 5
    mdu_op_i = 3'd4;
    a_i      = 32'd12345;
    b_i      = 32'd67;
    req_i    = 1'b1;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_result", 64'(result_o), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    #1;
    chk("post_rst_busy", 64'(busy_o), 64'd0);
    chk("post_rst_valid", 64'(valid_o), 64'd0);

    // Randomized operations, some issued back-to-back
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      run(rop, ra, rb, ref_res(rop, ra, rb), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Parametrised multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at configurable width. It sits beside the ALU in the execute stage. The core stalls on `busy_o` while an iterative operation runs. `flush_i` lets the interrupt/trap logic abort an in-flight operation.

## Interface
- `XLEN`, 32: operand/result width; must be even and ≥ 8.
- `clk_i`  in  1  clock, all state on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  1  start request; operands and op sampled on accept.
- `mdu_op_i`  in  3  operation code (funct3 encoding, from `mdu_opcodes_pkg`).
- `a_i`  in  XLEN  operand rs1.
- `b_i`  in  XLEN  operand rs2.
- `flush_i`  in  1  abort the current operation, synchronous.
- `busy_o`  out  1  operation in progress; new requests are ignored.
- `valid_o`  out  1  one-cycle pulse: `result_o` is new.
- `result_o`  out  XLEN  result, held until the next accept.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE or DONE + `req_i` → accept; next state depends on the op (below).
  - CALC → DONE when the step counter reaches 0.
  - DONE → IDLE when there is no `req_i`.
  - DONE + `req_i` → accept back-to-back.
- Accept: latch op, |a|, |b|, and the result-sign flags.
  - Sign rules: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats only `a` as signed. MULHU/DIVU/REMU treat both as unsigned.
  - Counter loads XLEN-1.
- Multiply: radix-2 shift-add over the unsigned magnitudes into a 2·XLEN accumulator.
  - Negate the product if the sign flag is set.
  - MUL returns bits [XLEN-1:0]; MULH* return bits [2·XLEN-1:XLEN].
- Divide: radix-2 restoring division, one quotient bit per cycle.
  - Quotient sign = sign(a) xor sign(b). Remainder sign = sign(a).
- Special cases resolved at accept, skipping CALC and going straight to DONE:
  - Divide by zero: DIV/DIVU → all-ones; REM/REMU → `a_i`.
  - Signed overflow (a = most-negative, b = -1): DIV → `a_i`; REM → 0.
- `flush_i` has priority over everything else.
  - Next state is IDLE, no `valid_o`, `result_o` unchanged.
  - A `req_i` in the same cycle is dropped.
- Unknown `mdu_op_i` values cannot occur: all 8 encodings are defined.

## Timing
- Reset values: state IDLE, `busy_o`=0, `valid_o`=0, `result_o`=0, counter 0.
- `busy_o` = (state == CALC). `valid_o` = (state == DONE).
- Iterative latency: accept at edge N → `valid_o` high in cycle N+XLEN+1. `busy_o` is high for XLEN cycles.
- Special-case latency: `valid_o` in the cycle after accept; `busy_o` never rises.
- Result register is written on the CALC→DONE (or accept→DONE) edge only.
- Reset asserted mid-operation immediately returns all outputs to reset values.

## Configuration
- `MDU_FAST_MUL_EN` defined: all MUL* ops use a single-cycle combinational XLEN×XLEN product and go accept→DONE, with `valid_o` one cycle after accept. Divides stay iterative.
- `MDU_FAST_MUL_EN` undefined: multiplies are iterative, with latency identical to divides.

## Structure
- `mdu_opcodes_pkg` holds:
  - the `mdu_op_e` enum: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7;
  - the `mdu_state_e` enum;
  - helper functions `is_div(op)`, `a_signed(op)`, `b_signed(op)`.
- Sub-module `mdu_iter_core`: holds the accumulator/remainder, operand shift registers and the one-step add/subtract datapath, parametrised by XLEN.
- The `mdu` top owns the FSM, counter, sign/special-case logic and the result register.

## Test plan
- MUL a=7, b=0xFFFFFFFD (-3) → `result_o`=0xFFFFFFEB.
  - `valid_o` 33 cycles after accept (1 cycle with `MDU_FAST_MUL_EN`).
  - `busy_o` high for 32 cycles (never with `MDU_FAST_MUL_EN`).
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM same → 0. All four: `valid_o` 1 cycle after accept, `busy_o` never high.
- DIV in flight, `flush_i` at CALC cycle 10 together with `req_i`:
  - No `valid_o`, `busy_o` low next cycle, `result_o` unchanged.
  - The request issued the following cycle is accepted and completes normally.
- `req_i` held high with new operands during CALC → ignored. In DONE → back-to-back accept, second `valid_o` exactly XLEN+1 cycles later.
- `rst_i` asserted at CALC cycle 5 → outputs zero immediately, state IDLE, no `valid_o` after release.
